cacheline_adaptor: RTL and testbench

- Memory-side responder for L1 cache line requests.
- Accepts one 256-bit line read (fill) or line write (writeback) from a cache datapath/controller, keyed by a 32-bit line-aligned address.
- Converts each request into a 4-beat, 64-bit burst on the physical memory interface, then returns a single-cycle line response.
- Sits between the instruction/data cache controllers (or their arbiter) and main memory.

---
 rtl/cacheline_adaptor_pkg.sv | 21 ++
 rtl/cacheline_adaptor.sv | 93 +++++++++
 tb/tb_cacheline_adaptor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared cache line/burst geometry and adaptor state enum
package cacheline_adaptor_pkg;

  localparam int s_offset  = 5;
  localparam int s_line    = 256;
  localparam int s_burst   = 64;
  localparam int burst_len = s_line / s_burst;
  localparam int cnt_w     = $clog2(burst_len);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } adaptor_state_e;

  function automatic logic [31:0] align_addr(input logic [31:0] addr);
    return addr & ~((32'd1 << s_offset) - 32'd1);
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts one cache line request into a 4-beat memory burst
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  adaptor_state_e state_q;
  logic [cnt_w-1:0] cnt_q;
  logic [31:0] addr_q;
  logic read_q, write_q, resp_q;
  // Fill and writeback lines are kept apart so a writeback never disturbs the last fill.
  logic [burst_len-1:0][s_burst-1:0] fill_q;
  logic [burst_len-1:0][s_burst-1:0] wb_q;
  logic last_beat;

  assign last_beat = (cnt_q == cnt_w'(burst_len - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
      fill_q  <= '0;
      wb_q    <= '0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (write_i) begin
            addr_q  <= align_addr(address_i);
            wb_q    <= line_i;
            cnt_q   <= '0;
            write_q <= 1'b1;
            state_q <= ST_WRITE;
          end else if (read_i) begin
            addr_q  <= align_addr(address_i);
            cnt_q   <= '0;
            read_q  <= 1'b1;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (resp_i) begin
            fill_q[cnt_q] <= burst_i;
            cnt_q         <= cnt_q + 1'b1;
            if (last_beat) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (resp_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign line_o    = fill_q;
  assign burst_o   = wb_q[cnt_q];
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed and randomized bench for cacheline_adaptor
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int n_pass  = 0;
  int n_total = 0;
  logic [255:0] last_fill = '0;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Cycles from first burst cycle until the 4th accepted beat, given a resp_i pattern.
  function automatic int pat_cycles(input logic [15:0] pat);
    int ones = 0;
    for (int i = 0; i < 16; i++) begin
      if (pat[i]) ones++;
      if (ones == 4) return i + 1;
    end
    return -1;
  endfunction

  // Called at a negedge while the adaptor is idle; returns at the negedge after DONE.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                         input logic [15:0] pat, input bit rnd);
    int k = 0;
    int cyc = 0;
    bit r;
    logic [31:0] al = {addr[31:5], 5'b0};
    read_i = 1'b1; address_i = addr; resp_i = 1'b0;
    @(negedge clk);
    address_i = $urandom;
    while (k < 4 && cyc < 40) begin
      chk("rd_read_o", read_o, 1'b1);
      chk("rd_addr", address_o, al);
      chk("rd_resp_early", resp_o, 1'b0);
      r = rnd ? 1'($urandom_range(0, 1)) : pat[cyc[3:0]];
      resp_i  = r;
      burst_i = r ? line[64*k +: 64] : {$urandom, $urandom};
      @(negedge clk);
      if (r) k++;
      cyc++;
    end
    if (k < 4) chk("rd_timeout", 256'(k), 256'd4);
    if (!rnd) chk("rd_latency", 256'(cyc), 256'(pat_cycles(pat)));
    resp_i = 1'b0;
    chk("rd_resp", resp_o, 1'b1);
    chk("rd_read_o_done", read_o, 1'b0);
    chk("rd_line", line_o, line);
    read_i = 1'b0; write_i = 1'b0;
    last_fill = line;
    @(negedge clk);
    chk("rd_resp_once", resp_o, 1'b0);
    chk("rd_line_hold", line_o, line);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input bit keep_read, input bit rnd);
    int k = 0;
    int cyc = 0;
    bit r;
    logic [31:0] al = {addr[31:5], 5'b0};
    write_i = 1'b1; read_i = keep_read; line_i = line; address_i = addr; resp_i = 1'b0;
    @(negedge clk);
    line_i = rand_line(); address_i = $urandom;
    while (k < 4 && cyc < 40) begin
      chk("wr_write_o", write_o, 1'b1);
      chk("wr_read_o", read_o, 1'b0);
      chk("wr_addr", address_o, al);
      chk("wr_burst", burst_o, line[64*k +: 64]);
      chk("wr_resp_early", resp_o, 1'b0);
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      resp_i = r;
      @(negedge clk);
      if (r) k++;
      cyc++;
    end
    if (k < 4) chk("wr_timeout", 256'(k), 256'd4);
    resp_i = 1'b0;
    chk("wr_resp", resp_o, 1'b1);
    chk("wr_write_o_done", write_o, 1'b0);
    chk("wr_fill_kept", line_o, last_fill);
    write_i = 1'b0;
    @(negedge clk);
    chk("wr_resp_once", resp_o, 1'b0);
  endtask

  initial begin
    logic [255:0] l;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_resp", resp_o, 1'b0);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_addr", address_o, 32'h0);
    chk("rst_burst", burst_o, 64'h0);
    chk("rst_line", line_o, 256'h0);
    rst = 1'b0;

    // resp_i while idle must be ignored
    resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (3) @(negedge clk);
    chk("idle_read_o", read_o, 1'b0);
    chk("idle_write_o", write_o, 1'b0);
    chk("idle_resp", resp_o, 1'b0);
    chk("idle_line", line_o, 256'h0);
    resp_i = 1'b0;

    // reset during a read burst
    read_i = 1'b1; address_i = 32'h0000_1234;
    @(negedge clk);
    chk("rstmid_read_o", read_o, 1'b1);
    chk("rstmid_addr", address_o, 32'h0000_1220);
    resp_i = 1'b1; burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
    @(negedge clk);
    burst_i = 64'hBBBB_BBBB_BBBB_BBBB;
    @(negedge clk);
    rst = 1'b1; read_i = 1'b0; resp_i = 1'b0;
    @(negedge clk);
    chk("rstmid_read_o_low", read_o, 1'b0);
    chk("rstmid_resp", resp_o, 1'b0);
    chk("rstmid_line", line_o, 256'h0);
    rst = 1'b0;
    resp_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_no_resp", resp_o, 1'b0);
    chk("rstmid_idle", read_o, 1'b0);
    resp_i = 1'b0;
    do_read(32'h0000_1234, rand_line(), 16'hFFFF, 1'b0);

    // zero-wait and gapped reads
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h8000_00E7, l, 16'hFFFF, 1'b0);
    do_read(32'h8000_00E7, l, 16'hFFD9, 1'b0);

    // writeback
    l = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    do_write(32'h0000_0540, l, 1'b0, 1'b0);

    // simultaneous request: write first, read still pending afterwards
    do_write(32'h0000_2000, rand_line(), 1'b1, 1'b0);
    do_read(32'h0000_3000, rand_line(), 16'hFFFF, 1'b0);

    // back-to-back writeback then fill
    do_write(32'h1234_5678, rand_line(), 1'b0, 1'b1);
    do_read(32'h9ABC_DEF0, rand_line(), 16'hFFFF, 1'b1);

    // randomized mix
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 1) == 0)
        do_write($urandom, rand_line(), 1'b0, 1'b1);
      else
        do_read($urandom, rand_line(), 16'hFFFF, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
